// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
// Holds the FSM state enum, the command codes and the frame width.
package spi_pkg;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = DATA_W + 2;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ,
        WAIT_TX,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial pins plus the RAM-side parallel bundle.
// slave = the SPI slave block, master = whatever drives it.
interface spi_slave_if #(
    parameter int DATA_W = spi_pkg::DATA_W
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_piso.sv
// spi_piso: parallel-load, MSB-first shift-out register with a
// registered serial output that idles at 0 when not loading/shifting.
module spi_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              q
);

    logic [DATA_W-1:0] sr;

    // MSB goes straight to q on load; the rest queue up in sr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            q  <= 1'b0;
        end else if (load) begin
            sr <= {din[DATA_W-2:0], 1'b0};
            q  <= din[DATA_W-1];
        end else if (shift) begin
            sr <= {sr[DATA_W-2:0], 1'b0};
            q  <= sr[DATA_W-1];
        end else begin
            q  <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: receives 10-bit command frames on MOSI, strobes them to
// the RAM, and serialises returned read bytes on MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);

    localparam int FW = DATA_W + 2;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [FW-2:0]     sh, sh_d;
    logic [FW-1:0]     rxd_d;
    logic              rxv_d;
    logic              load, shift;

    // State, counters, input shifter and registered rx outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            sh           <= '0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            sh           <= sh_d;
            bus.rx_data  <= rxd_d;
            bus.rx_valid <= rxv_d;
        end
    end

    // Next-state decode; SS_n high outside IDLE aborts the frame.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sh_d    = sh;
        rxd_d   = bus.rx_data;
        rxv_d   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        if (state != IDLE && bus.SS_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.SS_n) begin
                        state_d = CHK_CMD;
                        cnt_d   = '0;
                    end
                end
                CHK_CMD: begin
                    sh_d    = {sh[FW-3:0], bus.MOSI};
                    cnt_d   = 4'(FW - 2);
                    state_d = bus.MOSI ? READ : WRITE;
                end
                WRITE, READ: begin
                    sh_d = {sh[FW-3:0], bus.MOSI};
                    if (cnt == 4'd0) begin
                        rxd_d   = {sh, bus.MOSI};
                        rxv_d   = 1'b1;
                        state_d = (sh[FW-2:FW-3] == CMD_RD_DATA)
                                ? WAIT_TX : DONE;
                    end else begin
                        cnt_d = cnt - 4'd1;
                    end
                end
                WAIT_TX: begin
                    if (bus.tx_valid) begin
                        load    = 1'b1;
                        cnt_d   = 4'(DATA_W - 2);
                        state_d = SEND;
                    end
                end
                SEND: begin
                    shift = 1'b1;
                    if (cnt == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt - 4'd1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    spi_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (bus.tx_data),
        .q     (bus.MISO)
    );

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench for spi_slave; expected frames are
// queued as driven and popped when rx_valid strobes.
module tb_spi_slave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [9:0] sb[$];
    logic [9:0] last_rx = '0;
    logic       rv_prev = 1'b0;

    spi_slave_if #(.DATA_W(8)) bus();

    spi_slave #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    // Scoreboard pop on every rx_valid strobe, plus pulse-width check.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rv_prev)
                chk("rv_pulse", {31'b0, bus.rx_valid}, 32'd0);
            if (bus.rx_valid) begin
                if (sb.size() == 0) begin
                    chk("rx_unexp", {31'b0, bus.rx_valid}, 32'd0);
                end else begin
                    last_rx = sb.pop_front();
                    chk("rx_data", {22'b0, bus.rx_data}, {22'b0, last_rx});
                end
            end
            rv_prev = bus.rx_valid;
        end else begin
            rv_prev = 1'b0;
        end
    end

    // nbits<10 aborts; rst_k>=0 pulses reset after MISO bit rst_k.
    task automatic frame(input logic [9:0] f, input int nbits,
                         input bit do_tx, input logic [7:0] txb,
                         input bit noise, input int rst_k);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b1;
        if (nbits == 10) sb.push_back(f);
        for (int i = 9; i >= 10 - nbits; i--) begin
            @(negedge clk);
            bus.MOSI = f[i];
            bus.tx_valid = noise;
            if (noise) chk("miso_noise", {31'b0, bus.MISO}, 32'd0);
        end
        if (nbits < 10) begin
            @(negedge clk);
            bus.SS_n = 1'b1;
            @(negedge clk);
            chk("abort_rx", {22'b0, bus.rx_data}, {22'b0, last_rx});
            return;
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("miso_e10", {31'b0, bus.MISO}, 32'd0);
        if (f[9:8] == 2'b11 && do_tx) begin
            @(negedge clk);
            bus.tx_valid = 1'b1;
            bus.tx_data  = txb;
            for (int k = 7; k >= 0; k--) begin
                @(negedge clk);
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'h00;
                chk("miso_bit", {31'b0, bus.MISO}, {31'b0, txb[k]});
                if (k == rst_k) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_miso", {31'b0, bus.MISO}, 32'd0);
                    chk("rst_rxv", {31'b0, bus.rx_valid}, 32'd0);
                    chk("rst_rxd", {22'b0, bus.rx_data}, 32'd0);
                    last_rx = '0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    bus.SS_n = 1'b1;
                    return;
                end
            end
            @(negedge clk);
            chk("miso_tail", {31'b0, bus.MISO}, 32'd0);
        end else begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                bus.MOSI = j[0];
                chk("miso_hold", {31'b0, bus.MISO}, 32'd0);
            end
        end
        bus.SS_n = 1'b1;
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        #12;
        chk("rst_miso0", {31'b0, bus.MISO}, 32'd0);
        chk("rst_rxv0", {31'b0, bus.rx_valid}, 32'd0);
        chk("rst_rxd0", {22'b0, bus.rx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(10'h001, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h132, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h201, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h3FF, 10, 1'b1, 8'hA5, 1'b0, -1);
        frame(10'h2AA, 5, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h0C3, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h15A, 10, 1'b0, 8'h00, 1'b1, -1);
        frame(10'h37E, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h04D, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h300, 10, 1'b1, 8'h3C, 1'b0, 3);
        frame(10'h1E7, 10, 1'b0, 8'h00, 1'b0, -1);
        frame(10'h3C1, 10, 1'b1, 8'h96, 1'b0, -1);
        for (int r = 0; r < 6; r++) begin
            logic [7:0] b;
            logic [9:0] fr;
            b  = 8'($urandom_range(0, 255));
            fr = 10'($urandom_range(0, 1023));
            frame(fr, 10, 1'b1, b, 1'b0, -1);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
